// File: rtl/seq_mul_pkg.sv
// Shared definitions for the 4x3 shift-and-add multiplier.
//   A_W   : multiplicand width (must match the 4-bit ripple adder)
//   B_W   : multiplier width = number of CALC iterations
//   P_W   : product width
//   CNT_W : iteration counter width
package seq_mul_pkg;
  localparam int A_W   = 4;
  localparam int B_W   = 3;
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_mul_4x3_fouradder.sv
// FourAdder: 4-bit ripple-carry adder.
//   A, B : addends
//   Cin  : carry in
//   So   : sum
//   Cout : carry out
module FourAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] So,
  output logic       Cout
);
  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign So[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];
endmodule

// File: rtl/seq_mul_4x3.sv
// seq_mul_4x3: sequential unsigned shift-and-add multiplier (4b x 3b -> 7b).
// One multiplier bit is consumed per CALC cycle, LSB first, using a single
// FourAdder for the partial-product addition.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : multiply request, honoured in IDLE or DONE
//   a, b    : operands, captured on an accepted start
//   busy    : high while calculating
//   done    : one-cycle pulse, product valid from this cycle on
//   product : result, held until the next accepted start
// Build option SEQ_MUL_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are zero (latency 2..B_W+1 instead of a fixed B_W+1).
module seq_mul_4x3
  import seq_mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);
  state_t           state, state_nx;
  logic [A_W-1:0]   mcand, acc_hi, add_b, so;
  logic             cout;
  logic [B_W-1:0]   mplier;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   shifted, final_val;
  logic             last, accept;

  assign add_b = mplier[0] ? mcand : '0;

  FourAdder u_add (
    .A   (acc_hi),
    .B   (add_b),
    .Cin (1'b0),
    .So  (so),
    .Cout(cout)
  );

  // {Cout, So, mplier} >> 1: the consumed multiplier LSB falls off the end.
  assign shifted = {cout, so, mplier[B_W-1:1]};

`ifdef SEQ_MUL_EARLY_EXIT_EN
  // mplier holds original multiplier bits only in [B_W-1-cnt:0]; the upper
  // positions already carry product bits shifted in from the adder.
  logic [B_W-1:0]   rem_mask;
  logic [CNT_W-1:0] shamt;

  always_comb begin
    rem_mask = '0;
    for (int i = 1; i < B_W; i++)
      rem_mask[i] = (i < (B_W - int'(cnt)));
  end

  assign last      = (cnt == CNT_W'(B_W-1)) || ((mplier & rem_mask) == '0);
  assign shamt     = CNT_W'(B_W-1) - cnt;
  // Skipped iterations would only have shifted in zeros; do that alignment now.
  assign final_val = shifted >> shamt;
`else
  assign last      = (cnt == CNT_W'(B_W-1));
  assign final_val = shifted;
`endif

  assign accept = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? CALC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a;
      mplier <= b;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc_hi <= shifted[P_W-1:B_W];
      mplier <= shifted[B_W-1:0];
      cnt    <= cnt + CNT_W'(1);
      if (last) product <= final_val;
    end
  end
endmodule
